// File: rtl/hold_delay_scan_ctrl.sv
// Hold-delay scan sequencer: sweeps HoldDelay across a programmed range, arms the
// hold generator, launches one ADC conversion per HOLD pulse and streams each
// result, tagged with its delay, to the readout FIFO over valid/ready.
module hold_delay_scan_ctrl #(
    parameter int unsigned ADC_WIDTH = 12,
    parameter int unsigned EVT_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 reset_n,
    input  logic                 Start,
    input  logic                 Stop,
    input  logic [8:0]           StartDelay,
    input  logic [8:0]           StopDelay,
    input  logic [8:0]           DelayStep,
    input  logic [EVT_WIDTH-1:0] EventsPerStep,
    input  logic [7:0]           AdcSettle,
    input  logic                 HOLD,
    input  logic [ADC_WIDTH-1:0] AdcData,
    input  logic                 AdcDone,
    output logic [8:0]           HoldDelay,
    output logic                 Hold_en,
    output logic                 AdcStart,
    output logic [31:0]          DataOut,
    output logic                 DataValid,
    input  logic                 DataReady,
    output logic                 Busy,
    output logic                 ScanDone,
    output logic [7:0]           ConvErrCnt
);

    localparam int unsigned DLY_W     = 9;
    localparam int unsigned SUM_W     = DLY_W + 1;
    localparam int unsigned SETTLE_W  = 8;
    localparam int unsigned ERR_W     = 8;
    localparam int unsigned SAMPLE_W  = 12;
    localparam int unsigned EVT_EXT_W = EVT_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_HOLD = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_CONV      = 3'd4,
        ST_OUTPUT    = 3'd5,
        ST_NEXT      = 3'd6,
        ST_DONE      = 3'd7
    } state_t;

    state_t                state;
    state_t                stateNext;

    logic                  holdD;
    logic                  holdRise;
    logic                  stopPend;
    logic                  stopPendNext;
    logic                  latchCfg;
    logic                  captureWord;

    logic [DLY_W-1:0]      stopLat;
    logic [DLY_W-1:0]      stepLat;
    logic [EVT_WIDTH-1:0]  evtLat;
    logic [SETTLE_W-1:0]   settleLat;

    logic [DLY_W-1:0]      stepEff;
    logic [EVT_WIDTH-1:0]  evtEff;
    logic [SUM_W-1:0]      delaySum;
    logic [EVT_EXT_W-1:0]  evtInc;

    logic [DLY_W-1:0]      holdDelayNext;
    logic [EVT_WIDTH-1:0]  evtCnt;
    logic [EVT_WIDTH-1:0]  evtCntNext;
    logic [SETTLE_W-1:0]   settleCnt;
    logic [SETTLE_W-1:0]   settleCntNext;
    logic [ERR_W-1:0]      convErrNext;

    // Zero step / zero event count behave as one; the delay sum carries an extra bit so it cannot wrap.
    assign holdRise = HOLD & ~holdD;
    assign stepEff  = (stepLat == '0) ? DLY_W'(1) : stepLat;
    assign evtEff   = (evtLat == '0) ? EVT_WIDTH'(1) : evtLat;
    assign delaySum = SUM_W'(HoldDelay) + SUM_W'(stepEff);
    assign evtInc   = EVT_EXT_W'(evtCnt) + EVT_EXT_W'(1);

    // State register.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and next-datapath decode.
    always_comb begin
        stateNext     = state;
        holdDelayNext = HoldDelay;
        evtCntNext    = evtCnt;
        settleCntNext = settleCnt;
        convErrNext   = ConvErrCnt;
        stopPendNext  = stopPend;
        latchCfg      = 1'b0;
        captureWord   = 1'b0;

        case (state)
            ST_IDLE: begin
                stopPendNext = 1'b0;
                if (Start && !Stop) begin
                    latchCfg      = 1'b1;
                    holdDelayNext = StartDelay;
                    evtCntNext    = '0;
                    convErrNext   = '0;
                    stateNext     = ST_ARM;
                end
            end
            ST_ARM: begin
                if (Stop) begin
                    stateNext = ST_IDLE;
                end else if (!HOLD) begin
                    stateNext = ST_WAIT_HOLD;
                end
            end
            ST_WAIT_HOLD: begin
                if (Stop) begin
                    stateNext = ST_IDLE;
                end else if (holdRise) begin
                    settleCntNext = '0;
                    stateNext     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (Stop) begin
                    stateNext = ST_IDLE;
                end else if (settleCnt == settleLat) begin
                    stateNext = ST_CONV;
                end else begin
                    settleCntNext = settleCnt + SETTLE_W'(1);
                end
            end
            ST_CONV: begin
                // AdcDone wins over a simultaneous HOLD drop; HOLD low without AdcDone means the held level is gone.
                if (Stop) begin
                    stateNext = ST_IDLE;
                end else if (AdcDone) begin
                    captureWord = 1'b1;
                    stateNext   = ST_OUTPUT;
                end else if (!HOLD) begin
                    if (ConvErrCnt != '1) begin
                        convErrNext = ConvErrCnt + ERR_W'(1);
                    end
                    stateNext = ST_ARM;
                end
            end
            ST_OUTPUT: begin
                // Stop is deferred until the pending word has been accepted.
                if (Stop) begin
                    stopPendNext = 1'b1;
                end
                if (DataValid && DataReady) begin
                    if (Stop || stopPend) begin
                        stateNext = ST_IDLE;
                    end else if (evtInc >= EVT_EXT_W'(evtEff)) begin
                        stateNext = ST_NEXT;
                    end else begin
                        evtCntNext = evtCnt + EVT_WIDTH'(1);
                        stateNext  = ST_ARM;
                    end
                end
            end
            ST_NEXT: begin
                if (Stop) begin
                    stateNext = ST_IDLE;
                end else if (delaySum > SUM_W'(stopLat)) begin
                    stateNext = ST_DONE;
                end else begin
                    holdDelayNext = delaySum[DLY_W-1:0];
                    evtCntNext    = '0;
                    stateNext     = ST_ARM;
                end
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Datapath, configuration latches and registered outputs (decoded from the next state).
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            holdD      <= 1'b0;
            stopPend   <= 1'b0;
            stopLat    <= '0;
            stepLat    <= '0;
            evtLat     <= '0;
            settleLat  <= '0;
            evtCnt     <= '0;
            settleCnt  <= '0;
            HoldDelay  <= '0;
            ConvErrCnt <= '0;
            DataOut    <= '0;
            Hold_en    <= 1'b0;
            AdcStart   <= 1'b0;
            DataValid  <= 1'b0;
            Busy       <= 1'b0;
            ScanDone   <= 1'b0;
        end else begin
            holdD      <= HOLD;
            stopPend   <= stopPendNext;
            evtCnt     <= evtCntNext;
            settleCnt  <= settleCntNext;
            HoldDelay  <= holdDelayNext;
            ConvErrCnt <= convErrNext;
            if (latchCfg) begin
                stopLat   <= StopDelay;
                stepLat   <= DelayStep;
                evtLat    <= EventsPerStep;
                settleLat <= AdcSettle;
            end
            if (captureWord) begin
                DataOut <= {7'b0, HoldDelay, 4'b0, SAMPLE_W'(AdcData)};
            end
            Hold_en   <= (stateNext == ST_WAIT_HOLD);
            AdcStart  <= (stateNext == ST_SETTLE) && (settleCntNext == settleLat);
            DataValid <= (stateNext == ST_OUTPUT);
            Busy      <= (stateNext != ST_IDLE);
            ScanDone  <= (stateNext == ST_DONE);
        end
    end

endmodule

// File: tb/tb_hold_delay_scan_ctrl.sv
// Bench for hold_delay_scan_ctrl: a table of scan configurations with
// hand-computed results, plus directed sequences for stall, abort, stop and reset.
`timescale 1ns/1ps
module tb_hold_delay_scan_ctrl;

    localparam int W_HOLDEN = 0;
    localparam int W_VALID  = 1;
    localparam int W_ADCST  = 2;
    localparam int W_DONE   = 3;
    localparam int W_IDLE   = 4;

    logic        Clk = 1'b0;
    logic        reset_n;
    logic        Start, Stop;
    logic [8:0]  StartDelay, StopDelay, DelayStep;
    logic [15:0] EventsPerStep;
    logic [7:0]  AdcSettle;
    logic        HOLD;
    logic [11:0] AdcData;
    logic        AdcDone;
    logic [8:0]  HoldDelay;
    logic        Hold_en, AdcStart;
    logic [31:0] DataOut;
    logic        DataValid, DataReady, Busy, ScanDone;
    logic [7:0]  ConvErrCnt;

    hold_delay_scan_ctrl #(.ADC_WIDTH(12), .EVT_WIDTH(16)) dut (
        .Clk(Clk), .reset_n(reset_n), .Start(Start), .Stop(Stop),
        .StartDelay(StartDelay), .StopDelay(StopDelay), .DelayStep(DelayStep),
        .EventsPerStep(EventsPerStep), .AdcSettle(AdcSettle), .HOLD(HOLD),
        .AdcData(AdcData), .AdcDone(AdcDone), .HoldDelay(HoldDelay),
        .Hold_en(Hold_en), .AdcStart(AdcStart), .DataOut(DataOut),
        .DataValid(DataValid), .DataReady(DataReady), .Busy(Busy),
        .ScanDone(ScanDone), .ConvErrCnt(ConvErrCnt)
    );

    always #5 Clk = ~Clk;

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;

    // Responder knobs and monitor state
    bit          respEn    = 1'b1;
    bit          shortNext = 1'b0;
    int          holdLen   = 20;
    int          shortLen  = 6;
    int          adcLat    = 5;
    int          curSettle = 0;
    int          riseCyc   = 0;
    int          doneCyc   = 0;
    int          scanDoneCnt = 0;
    logic        holdPrev  = 1'b0;
    logic        dvPrev    = 1'b0;
    logic [31:0] words[$];

    typedef struct {
        logic [8:0]  startD;
        logic [8:0]  stopD;
        logic [8:0]  step;
        logic [15:0] events;
        logic [7:0]  settle;
        int          hLen;
        logic [11:0] adc;
        int          expWords;
        logic [8:0]  expLast;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic waitCond(input int which, input int budget, input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge Clk);
            case (which)
                W_HOLDEN: ok = Hold_en;
                W_VALID:  ok = DataValid;
                W_ADCST:  ok = AdcStart;
                W_DONE:   ok = ScanDone;
                default:  ok = !Busy;
            endcase
            if (ok) break;
        end
        if (!ok) begin
            nTests++;
            nFail++;
            $display("FAIL %s: timeout after %0d cycles", name, budget);
        end
    endtask

    task automatic applyReset();
        @(posedge Clk); #1;
        reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        reset_n = 1'b1;
    endtask

    task automatic startScan(input logic [8:0] s, input logic [8:0] e, input logic [8:0] st,
                             input logic [15:0] ev, input logic [7:0] se, input logic [11:0] adc);
        words.delete();
        scanDoneCnt = 0;
        @(posedge Clk); #1;
        StartDelay = s; StopDelay = e; DelayStep = st; EventsPerStep = ev; AdcSettle = se;
        AdcData = adc; curSettle = int'(se);
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        // Scrambled config after the accepted Start must not affect the scan
        StartDelay = ~s; StopDelay = ~e; DelayStep = st + 9'd1;
        EventsPerStep = ev + 16'd3; AdcSettle = se + 8'd5;
    endtask

    task automatic runScan(input vec_t v, input string tag);
        bit ok;
        int d, ev, st;
        logic [31:0] expW[$];
        logic [31:0] got;
        holdLen = v.hLen;
        startScan(v.startD, v.stopD, v.step, v.events, v.settle, v.adc);
        waitCond(W_DONE, 4000, {tag, " scandone"}, ok);
        @(negedge Clk);
        ev = (v.events == 16'd0) ? 1 : int'(v.events);
        st = (v.step == 9'd0) ? 1 : int'(v.step);
        d  = int'(v.startD);
        do begin
            for (int k = 0; k < ev; k++) expW.push_back((32'(d) << 16) | 32'(v.adc));
            d += st;
        end while (d <= int'(v.stopD));
        check({tag, " words"}, 32'(words.size()), 32'(v.expWords));
        for (int k = 0; k < expW.size(); k++) begin
            got = (k < words.size()) ? words[k] : 32'hDEAD_BEEF;
            check($sformatf("%s word%0d", tag, k), got, expW[k]);
        end
        check({tag, " scandone count"}, 32'(scanDoneCnt), 32'd1);
        check({tag, " last delay"}, 32'(HoldDelay), 32'(v.expLast));
        check({tag, " busy"}, 32'(Busy), 32'd0);
        check({tag, " converr"}, 32'(ConvErrCnt), 32'd0);
        if (!ok) applyReset();
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // HOLD / ADC responder: pulses HOLD when armed, answers AdcStart after adcLat cycles
    initial begin
        int holdTimer, adcTimer;
        HOLD = 1'b0; AdcDone = 1'b0; holdTimer = 0; adcTimer = 0;
        forever begin
            @(posedge Clk); #1;
            AdcDone = 1'b0;
            if (!reset_n) begin
                HOLD = 1'b0; holdTimer = 0; adcTimer = 0;
            end else begin
                if (HOLD) begin
                    if (holdTimer <= 1) HOLD = 1'b0;
                    else holdTimer--;
                end else if (Hold_en && respEn) begin
                    HOLD = 1'b1;
                    holdTimer = shortNext ? shortLen : holdLen;
                    shortNext = 1'b0;
                end
                if (AdcStart) begin
                    adcTimer = adcLat;
                end else if (adcTimer > 0) begin
                    adcTimer--;
                    if (adcTimer == 0) AdcDone = 1'b1;
                end
            end
        end
    end

    // Output monitor: latency checks, word capture, ScanDone count
    always @(negedge Clk) begin
        if (reset_n) begin
            if (HOLD && !holdPrev) riseCyc = cyc;
            if (AdcStart) check("adcstart latency", 32'(cyc - riseCyc), 32'(curSettle + 1));
            if (AdcDone) doneCyc = cyc;
            if (DataValid && !dvPrev) check("datavalid latency", 32'(cyc - doneCyc), 32'd1);
            if (DataValid && DataReady) words.push_back(DataOut);
            if (ScanDone) scanDoneCnt++;
        end
        holdPrev = HOLD;
        dvPrev   = DataValid;
    end

    initial begin
        bit ok;
        vecs[0] = '{9'd0,   9'd8,   9'd4,   16'd2, 8'd3, 20, 12'hABC, 6, 9'd8};
        vecs[1] = '{9'd510, 9'd511, 9'd3,   16'd1, 8'd0, 20, 12'h123, 1, 9'd510};
        vecs[2] = '{9'd5,   9'd9,   9'd0,   16'd0, 8'd2, 20, 12'h5A5, 5, 9'd9};
        vecs[3] = '{9'd100, 9'd50,  9'd7,   16'd3, 8'd1, 20, 12'hFFF, 3, 9'd100};
        vecs[4] = '{9'd20,  9'd22,  9'd2,   16'd1, 8'd3, 9,  12'h321, 2, 9'd22};
        vecs[5] = '{9'd511, 9'd511, 9'd511, 16'd1, 8'd0, 20, 12'h001, 1, 9'd511};

        reset_n = 1'b0; Start = 1'b0; Stop = 1'b0; DataReady = 1'b1;
        StartDelay = '0; StopDelay = '0; DelayStep = '0; EventsPerStep = '0; AdcSettle = '0;
        AdcData = '0;
        repeat (3) @(negedge Clk);
        check("rst HoldDelay", 32'(HoldDelay), 32'd0);
        check("rst Hold_en", 32'(Hold_en), 32'd0);
        check("rst AdcStart", 32'(AdcStart), 32'd0);
        check("rst DataOut", DataOut, 32'd0);
        check("rst DataValid", 32'(DataValid), 32'd0);
        check("rst Busy", 32'(Busy), 32'd0);
        check("rst ScanDone", 32'(ScanDone), 32'd0);
        check("rst ConvErrCnt", 32'(ConvErrCnt), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) runScan(vecs[i], $sformatf("vec%0d", i));

        // Basic sweep word for delay 4
        runScan(vecs[0], "basic");
        check("basic delay4 word", (words.size() > 2) ? words[2] : 32'h0, 32'h0004_0ABC);

        // Backpressure: 10-cycle stall holds the word and keeps the generator disarmed
        holdLen = 20; DataReady = 1'b0;
        startScan(9'd0, 9'd0, 9'd1, 16'd2, 8'd3, 12'hABC);
        waitCond(W_VALID, 200, "stall valid", ok);
        for (int n = 0; n < 10; n++) begin
            @(negedge Clk);
            check("stall DataValid", 32'(DataValid), 32'd1);
            check("stall DataOut", DataOut, 32'h0000_0ABC);
            check("stall Hold_en", 32'(Hold_en), 32'd0);
        end
        @(posedge Clk); #1; DataReady = 1'b1;
        waitCond(W_DONE, 2000, "stall scandone", ok);
        @(negedge Clk);
        check("stall words", 32'(words.size()), 32'd2);
        check("stall word0", (words.size() > 0) ? words[0] : 32'h0, 32'h0000_0ABC);

        // Conversion abort: first HOLD pulse too short, scan still yields its two words
        shortNext = 1'b1;
        startScan(9'd40, 9'd40, 9'd1, 16'd2, 8'd3, 12'hABC);
        waitCond(W_DONE, 2000, "abort scandone", ok);
        @(negedge Clk);
        check("abort converr", 32'(ConvErrCnt), 32'd1);
        check("abort words", 32'(words.size()), 32'd2);
        check("abort word0", (words.size() > 0) ? words[0] : 32'h0, 32'h0028_0ABC);
        check("abort word1", (words.size() > 1) ? words[1] : 32'h0, 32'h0028_0ABC);

        // Stop in WAIT_HOLD
        respEn = 1'b0;
        startScan(9'd0, 9'd8, 9'd4, 16'd2, 8'd3, 12'hABC);
        waitCond(W_HOLDEN, 20, "stopwait armed", ok);
        @(posedge Clk); #1; Stop = 1'b1;
        @(posedge Clk); #1; Stop = 1'b0;
        @(negedge Clk);
        check("stopwait Hold_en", 32'(Hold_en), 32'd0);
        check("stopwait Busy", 32'(Busy), 32'd0);
        repeat (5) @(negedge Clk);
        check("stopwait scandone", 32'(scanDoneCnt), 32'd0);
        check("stopwait words", 32'(words.size()), 32'd0);
        respEn = 1'b1;

        // Start and Stop together while idle: ignored
        @(posedge Clk); #1; Start = 1'b1; Stop = 1'b1;
        @(posedge Clk); #1; Start = 1'b0; Stop = 1'b0;
        @(negedge Clk);
        check("start+stop Busy", 32'(Busy), 32'd0);

        // Stop during a stalled OUTPUT: word delivered, then idle
        DataReady = 1'b0;
        startScan(9'd0, 9'd8, 9'd4, 16'd2, 8'd3, 12'hABC);
        waitCond(W_VALID, 200, "stopout valid", ok);
        @(posedge Clk); #1; Stop = 1'b1;
        @(posedge Clk); #1; Stop = 1'b0;
        repeat (3) @(negedge Clk);
        check("stopout DataValid held", 32'(DataValid), 32'd1);
        check("stopout Busy held", 32'(Busy), 32'd1);
        @(posedge Clk); #1; DataReady = 1'b1;
        waitCond(W_IDLE, 20, "stopout idle", ok);
        check("stopout words", 32'(words.size()), 32'd1);
        check("stopout word0", (words.size() > 0) ? words[0] : 32'h0, 32'h0000_0ABC);
        check("stopout scandone", 32'(scanDoneCnt), 32'd0);
        check("stopout DataValid", 32'(DataValid), 32'd0);
        check("stopout Hold_en", 32'(Hold_en), 32'd0);

        // Async reset while in CONV after one aborted conversion
        shortNext = 1'b1;
        startScan(9'd0, 9'd8, 9'd4, 16'd2, 8'd3, 12'hABC);
        waitCond(W_ADCST, 200, "rstconv adcstart1", ok);
        waitCond(W_ADCST, 200, "rstconv adcstart2", ok);
        check("rstconv converr before", 32'(ConvErrCnt), 32'd1);
        @(posedge Clk); #2;
        reset_n = 1'b0;
        #1;
        check("rstconv HoldDelay", 32'(HoldDelay), 32'd0);
        check("rstconv Hold_en", 32'(Hold_en), 32'd0);
        check("rstconv AdcStart", 32'(AdcStart), 32'd0);
        check("rstconv DataOut", DataOut, 32'd0);
        check("rstconv DataValid", 32'(DataValid), 32'd0);
        check("rstconv Busy", 32'(Busy), 32'd0);
        check("rstconv ScanDone", 32'(ScanDone), 32'd0);
        check("rstconv ConvErrCnt", 32'(ConvErrCnt), 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        reset_n = 1'b1;
        runScan(vecs[0], "postreset");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/hold_delay_scan_ctrl.md
Name: hold_delay_scan_ctrl

Overview:
Sequencer for the trigger-to-hold delay path. It sweeps HoldDelay from StartDelay to StopDelay in steps of DelayStep and arms the hold generator through Hold_en. Each HOLD pulse starts one external ADC conversion of the held analogue output, and the conversion result, tagged with the current delay, is pushed into the readout FIFO over a valid/ready interface. It sits between the slow-control register file and the hold generator, ADC interface and readout FIFO, and produces a hold-delay scan that locates the shaper peak.

Parameters:
ADC_WIDTH, 12, ADC sample width (max 12, zero-padded in DataOut)
EVT_WIDTH, 16, width of EventsPerStep and the event counter

Ports:
Clk  in  1  system clock, 500 MHz
reset_n  in  1  asynchronous active-low reset
Start  in  1  one-cycle pulse, begin scan (ignored unless IDLE)
Stop  in  1  level/pulse, abort scan
StartDelay  in  9  first HoldDelay value
StopDelay  in  9  last allowed HoldDelay value
DelayStep  in  9  increment per step (0 treated as 1)
EventsPerStep  in  EVT_WIDTH  samples per step (0 treated as 1)
AdcSettle  in  8  cycles from HOLD rise to AdcStart
HOLD  in  1  hold from hold generator, active high, same clock domain
AdcData  in  ADC_WIDTH  conversion result, valid when AdcDone=1
AdcDone  in  1  one-cycle pulse, conversion complete
HoldDelay  out  9  delay driven to hold generator
Hold_en  out  1  enable to hold generator
AdcStart  out  1  one-cycle conversion request
DataOut  out  32  {7'b0, HoldDelay[8:0], 4'b0, AdcData zero-extended to 12}
DataValid  out  1  DataOut valid
DataReady  in  1  FIFO accepts
Busy  out  1  high in every state except IDLE
ScanDone  out  1  one-cycle pulse at normal scan completion
ConvErrCnt  out  8  saturating count of aborted conversions; cleared on Start

Behaviour:
- Reset: all outputs 0. HoldDelay=0, state IDLE, internal counters 0.
- Inputs StartDelay, StopDelay, DelayStep, EventsPerStep and AdcSettle are latched on an accepted Start. Changes during a scan have no effect.
- HOLD rise detect: one register HoldD; HoldRise = HOLD & ~HoldD.
- IDLE: on Start, latch inputs, HoldDelay<=StartDelay, EvtCnt<=0, ConvErrCnt<=0, go to ARM.
- ARM: Hold_en=0. Once HOLD==0, go to WAIT_HOLD.
- WAIT_HOLD: Hold_en=1. On HoldRise: Hold_en<=0, SettleCnt<=0, go to SETTLE.
- SETTLE: count up to AdcSettle. When SettleCnt==AdcSettle, AdcStart=1 for exactly one cycle and go to CONV. AdcSettle=0 gives AdcStart on the cycle after HoldRise.
- CONV: on AdcDone, capture AdcData and go to OUTPUT.
  - If HOLD falls before AdcDone, ConvErrCnt increments (saturates at 255), the sample is discarded, EvtCnt is not incremented, and the state returns to ARM.
  - If AdcDone and HOLD fall occur in the same cycle, the sample is valid.
- OUTPUT: DataValid=1 with DataOut stable until DataValid&DataReady. In the cycle after acceptance, DataValid=0. Then:
  - EvtCnt+1 >= effective EventsPerStep: go to NEXT.
  - Otherwise EvtCnt++ and go to ARM.
- NEXT: compute sum in 10 bits, sum = HoldDelay + effective DelayStep.
  - sum > StopDelay: go to DONE.
  - Otherwise HoldDelay<=sum[8:0], EvtCnt<=0, go to ARM.
  - StartDelay > StopDelay yields a single step at StartDelay. Because the sum is 10 bits, no wrap past 511.
- DONE: ScanDone=1 for one cycle, then go to IDLE. HoldDelay keeps its last value.
- Stop:
  - In any state except OUTPUT and IDLE: next state IDLE, Hold_en=0, no ScanDone, no output word.
  - In OUTPUT: Stop is remembered and honoured right after the handshake completes. DataValid never drops without acceptance.
  - Stop and Start in the same cycle while IDLE: Start is ignored.
- Start while Busy is ignored.
- Latency: AdcStart rises AdcSettle+1 cycles after the HOLD rising edge. DataValid rises 1 cycle after AdcDone.
- Reset mid-scan: immediate return to reset values. Any partial word is lost.

Test Plan:
- Basic sweep: Start=0, Stop=8, Step=4, Events=2, AdcSettle=3, HOLD pulse 20 cycles, AdcDone 5 cycles after AdcStart with AdcData=0xABC, Ready=1 -> 6 words, delays 0,0,4,4,8,8, DataOut for delay 4 = 0x0004_0ABC, one ScanDone, AdcStart 4 cycles after each HOLD rise.
- Backpressure: DataReady=0 for 10 cycles -> DataValid and DataOut stable for the full stall, no new Hold_en until acceptance.
- Conversion abort: HOLD falls before AdcDone -> ConvErrCnt=1, no word, re-arm at the same delay, step still yields EventsPerStep valid words.
- Boundaries:
  - Start=510, Stop=511, Step=3 -> single step at 510, no wrap.
  - Step=0 and Events=0 -> treated as 1.
  - Start>Stop -> one step only.
- Stop in WAIT_HOLD -> Hold_en=0 next cycle, IDLE, no ScanDone.
- Stop during a stalled OUTPUT -> word delivered, then IDLE.
- Async reset asserted in CONV -> all outputs 0 immediately. A later Start runs a clean scan with ConvErrCnt=0.
